target_spawner: RTL and testbench
=================================

TARGET_SPAWNER -- requirements
Module: target_spawner

Interface
REQ-001 Parameter LIFE_TICKS, default 8, range 1..15: ticks a spawned target stays lit before expiring.
REQ-002 Parameter MAX_MISS, default 5, range 1..15: expired-target count that ends the game.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 tick  input  1  single-cycle game-step strobe; spawn and aging happen only when tick=1.
REQ-006 start  input  1  level; starts or restarts a game.
REQ-007 level  input  2  difficulty: 00 easy, 01 normal, 10/11 extreme.
REQ-008 prn  input  5  pseudo-random lane pattern from the 5-bit LFSR stage.
REQ-009 easy_t, normal_t, extreme_t  input  1 each  spawn-permit flags from the LFSR stage.
REQ-010 btn  input  5  player buttons, already synchronised, active-high, one per lane.
REQ-011 lit  output  5  lanes currently holding a target.
REQ-012 score  output  8  hit count.
REQ-013 misses  output  4  expired-target count.
REQ-014 game_over  output  1  high while in OVER.
REQ-015 state  output  2  FSM state: 00 IDLE, 01 RUN, 10 OVER.

Function
REQ-016 FSM SHALL have states IDLE, RUN, OVER; 11 is unreachable and SHALL recover to IDLE.
REQ-017 IDLE: lit=0, score and misses hold; start=1 -> RUN next cycle with score=0, misses=0, lit=0, all lane timers 0.
REQ-018 OVER: lit=0, score/misses frozen, game_over=1; start=1 -> RUN next cycle, same clearing as REQ-017.
REQ-019 RUN: start is ignored.
REQ-020 Spawn permit SHALL be the flag selected by level: easy_t (00), normal_t (01), extreme_t (1x).
REQ-021 In RUN on tick with permit=1: every lane i with prn[i]=1 and lit[i]=0 SHALL become lit next cycle, with its timer loaded to LIFE_TICKS-1.
REQ-022 In RUN on tick: every lane lit before the tick with timer>0 SHALL decrement its timer; a lit lane with timer=0 SHALL expire (lit cleared, counted as a miss).
REQ-023 A lane that expires on a tick SHALL NOT be re-spawned by the same tick.
REQ-024 Button edge: per-lane register of the previous btn value, reset 0; a hit is btn[i]=1 with previous=0, in RUN, while lit[i]=1.
REQ-025 A hit SHALL clear lit[i] next cycle and increase score by 1; rising edges on unlit lanes, or outside RUN, SHALL have no effect.
REQ-026 Hit and expiry on the same lane in the same cycle: the hit wins (score+1, no miss).
REQ-027 Hit and spawn on the same lane in the same cycle: the hit clears the lane and the spawn is suppressed for that lane.
REQ-028 Multiple simultaneous hits SHALL add their popcount to score, saturating at 255.
REQ-029 Multiple simultaneous expiries SHALL add their popcount to misses, saturating at MAX_MISS.
REQ-030 When updated misses >= MAX_MISS, the FSM SHALL enter OVER on that same clock edge, and lit SHALL be 0 from that edge.
REQ-031 All outputs SHALL be registered; lit, score, misses and state reflect an event one cycle after the sampling edge.

Reset
REQ-032 rst=1 SHALL immediately force state=IDLE, lit=0, score=0, misses=0, game_over=0, all timers 0, and all button-history bits 0, including mid-game.
REQ-033 After rst falls, operation SHALL resume at the first clk edge in IDLE.

Verification
REQ-034 rst pulse during RUN with lit=10101, score=7 -> all outputs 0 and state=00 without a clock edge.
REQ-035 IDLE, start=1 -> state=01; level=00, tick with easy_t=1 and prn=10011 -> lit=10011 one cycle later.
REQ-036 LIFE_TICKS=8, single lane lit, no presses -> lane clears on the 8th subsequent tick and misses=1.
REQ-037 lit=00011, btn 00000 -> 00011 in one cycle -> lit=00000 and score+2; holding btn high -> no further score change.
REQ-038 Hit on a lane on the same cycle as its expiry tick -> score+1, misses unchanged; hit on a lane while tick spawns it -> lane stays clear.
REQ-039 MAX_MISS=5, misses=4, two lanes expire on one tick -> misses=5, state=10, game_over=1, lit=0; then start=1 -> state=01, score=0, misses=0.

Source files
------------

// File: rtl/target_spawner.sv
// Five-lane target game core: spawns lit targets from the LFSR pattern,
// ages them on tick, scores button hits and ends the game on too many misses.
module target_spawner #(
    parameter int unsigned LIFE_TICKS = 8,
    parameter int unsigned MAX_MISS   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic [1:0] level,
    input  logic [4:0] prn,
    input  logic       easy_t,
    input  logic       normal_t,
    input  logic       extreme_t,
    input  logic [4:0] btn,
    output logic [4:0] lit,
    output logic [7:0] score,
    output logic [3:0] misses,
    output logic       game_over,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_OVER = 2'b10
    } state_e;

    localparam logic [3:0] LOAD = 4'(LIFE_TICKS - 1);
    localparam logic [4:0] MAXM = 5'(MAX_MISS);

    state_e          state_q, state_d;
    logic [4:0]      lit_q, lit_d;
    logic [7:0]      score_q, score_d;
    logic [3:0]      misses_q, misses_d;
    logic            over_q;
    logic [4:0]      btn_q;
    logic [4:0][3:0] timer_q, timer_d;

    logic       permit;
    logic [4:0] hit, expire, spawn;
    logic [8:0] score_sum;
    logic [4:0] miss_sum;

    function automatic logic [2:0] pop5(input logic [4:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 5; i++) n = n + {2'b00, v[i]};
        return n;
    endfunction

    always_comb begin
        permit = easy_t;
        if (level[1])      permit = extreme_t;
        else if (level[0]) permit = normal_t;
    end

    always_comb begin
        state_d   = state_q;
        lit_d     = lit_q;
        score_d   = score_q;
        misses_d  = misses_q;
        timer_d   = timer_q;
        hit       = 5'b0;
        expire    = 5'b0;
        spawn     = 5'b0;
        score_sum = 9'd0;
        miss_sum  = 5'd0;
        case (state_q)
            S_IDLE, S_OVER: begin
                lit_d = 5'b0;
                if (start) begin
                    state_d  = S_RUN;
                    score_d  = 8'd0;
                    misses_d = 4'd0;
                    timer_d  = '0;
                end
            end
            S_RUN: begin
                hit = btn & ~btn_q & lit_q;
                if (tick) begin
                    for (int i = 0; i < 5; i++)
                        expire[i] = lit_q[i] & ~hit[i] & (timer_q[i] == 4'd0);
                    // lit lanes (incl. ones expiring now) never re-spawn
                    if (permit) spawn = prn & ~lit_q;
                end
                for (int i = 0; i < 5; i++) begin
                    if (hit[i] || expire[i])
                        timer_d[i] = 4'd0;
                    else if (spawn[i])
                        timer_d[i] = LOAD;
                    else if (tick && lit_q[i])
                        timer_d[i] = timer_q[i] - 4'd1;
                end
                lit_d     = (lit_q & ~hit & ~expire) | spawn;
                score_sum = {1'b0, score_q} + {6'd0, pop5(hit)};
                score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
                miss_sum  = {1'b0, misses_q} + {2'b00, pop5(expire)};
                if (miss_sum >= MAXM) begin
                    misses_d = MAXM[3:0];
                    state_d  = S_OVER;
                    lit_d    = 5'b0;
                end else begin
                    misses_d = miss_sum[3:0];
                end
            end
            default: begin
                state_d = S_IDLE;
                lit_d   = 5'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lit_q    <= 5'b0;
            score_q  <= 8'd0;
            misses_q <= 4'd0;
            over_q   <= 1'b0;
            btn_q    <= 5'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            lit_q    <= lit_d;
            score_q  <= score_d;
            misses_q <= misses_d;
            over_q   <= (state_d == S_OVER);
            btn_q    <= btn;
            timer_q  <= timer_d;
        end
    end

    assign lit       = lit_q;
    assign score     = score_q;
    assign misses    = misses_q;
    assign game_over = over_q;
    assign state     = state_q;

endmodule

// File: tb/tb_target_spawner.sv
// Directed bench for target_spawner: spawn, aging, hits, misses,
// game over, restart, level select, saturation and async reset.
module tb_target_spawner;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [1:0] level = 2'b00;
    logic [4:0] prn = 5'b0;
    logic       easy_t = 1'b0;
    logic       normal_t = 1'b0;
    logic       extreme_t = 1'b0;
    logic [4:0] btn = 5'b0;
    logic [4:0] lit;
    logic [7:0] score;
    logic [3:0] misses;
    logic       game_over;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    target_spawner #(.LIFE_TICKS(8), .MAX_MISS(5)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .level(level),
        .prn(prn), .easy_t(easy_t), .normal_t(normal_t),
        .extreme_t(extreme_t), .btn(btn), .lit(lit), .score(score),
        .misses(misses), .game_over(game_over), .state(state)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] l,
                           input logic [7:0] s, input logic [3:0] m,
                           input logic [1:0] st, input logic go);
        chk({tag, ".lit"}, 32'(lit), 32'(l));
        chk({tag, ".score"}, 32'(score), 32'(s));
        chk({tag, ".misses"}, 32'(misses), 32'(m));
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".game_over"}, 32'(game_over), 32'(go));
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk_all("reset", 5'b0, 8'd0, 4'd0, 2'b00, 1'b0);
        #10 rst = 1'b0;
        cyc();
        chk("idle_state", 32'(state), 32'd0);

        start = 1'b1;
        cyc();
        start = 1'b0;
        chk_all("start", 5'b0, 8'd0, 4'd0, 2'b01, 1'b0);

        tick = 1'b1; easy_t = 1'b1; prn = 5'b10011;
        cyc();
        tick = 1'b0; easy_t = 1'b0;
        chk("spawn_lit", 32'(lit), 32'b10011);

        btn = 5'b00011;
        cyc();
        chk("hit2_lit", 32'(lit), 32'b10000);
        chk("hit2_score", 32'(score), 32'd2);
        cyc();
        chk("hold_score", 32'(score), 32'd2);
        btn = 5'b0;
        cyc();

        tick = 1'b1;
        repeat (7) cyc();
        chk("age7_lit", 32'(lit), 32'b10000);
        chk("age7_miss", 32'(misses), 32'd0);
        cyc();
        tick = 1'b0;
        chk("expire_lit", 32'(lit), 32'b0);
        chk("expire_miss", 32'(misses), 32'd1);

        tick = 1'b1; easy_t = 1'b1; prn = 5'b00100;
        cyc();
        easy_t = 1'b0;
        repeat (7) cyc();
        btn = 5'b00100;
        cyc();
        tick = 1'b0; btn = 5'b0;
        chk_all("hit_at_expiry", 5'b0, 8'd3, 4'd1, 2'b01, 1'b0);
        cyc();

        tick = 1'b1; easy_t = 1'b1; prn = 5'b01000;
        cyc();
        chk("spawn3_lit", 32'(lit), 32'b01000);
        btn = 5'b01000;
        cyc();
        tick = 1'b0; easy_t = 1'b0; btn = 5'b0;
        chk("hit_vs_spawn_lit", 32'(lit), 32'b0);
        chk("hit_vs_spawn_score", 32'(score), 32'd4);
        cyc();

        btn = 5'b00001;
        cyc();
        btn = 5'b0;
        chk("unlit_press", 32'(score), 32'd4);
        cyc();

        tick = 1'b1; easy_t = 1'b1; prn = 5'b00111;
        cyc();
        easy_t = 1'b0;
        repeat (8) cyc();
        chk_all("miss3", 5'b0, 8'd4, 4'd4, 2'b01, 1'b0);
        easy_t = 1'b1; prn = 5'b00011;
        cyc();
        easy_t = 1'b0;
        repeat (7) cyc();
        chk("pre_over_lit", 32'(lit), 32'b00011);
        cyc();
        tick = 1'b0;
        chk_all("over", 5'b0, 8'd4, 4'd5, 2'b10, 1'b1);
        btn = 5'b00011;
        cyc();
        btn = 5'b0;
        chk("over_press", 32'(score), 32'd4);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk_all("restart", 5'b0, 8'd0, 4'd0, 2'b01, 1'b0);

        tick = 1'b1; easy_t = 1'b1; prn = 5'b11111;
        cyc();
        tick = 1'b0; btn = 5'b11111;
        cyc();
        chk("hit5_score", 32'(score), 32'd5);
        btn = 5'b0;
        cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0; easy_t = 1'b0; btn = 5'b01010;
        cyc();
        chk("pre_rst_lit", 32'(lit), 32'b10101);
        chk("pre_rst_score", 32'(score), 32'd7);
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 5'b0, 8'd0, 4'd0, 2'b00, 1'b0);
        btn = 5'b0;
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_state", 32'(state), 32'd0);

        start = 1'b1;
        cyc();
        chk("start2", 32'(state), 32'd1);
        level = 2'b01; easy_t = 1'b1; prn = 5'b00001; tick = 1'b1;
        cyc();
        chk("lvl_normal_off", 32'(lit), 32'b0);
        easy_t = 1'b0; normal_t = 1'b1;
        cyc();
        chk("lvl_normal_on", 32'(lit), 32'b00001);
        level = 2'b10; normal_t = 1'b0; extreme_t = 1'b1; prn = 5'b00010;
        cyc();
        chk("lvl_extreme_on", 32'(lit), 32'b00011);
        level = 2'b11; extreme_t = 1'b0; normal_t = 1'b1; easy_t = 1'b1;
        prn = 5'b00100;
        cyc();
        chk("lvl_extreme_off", 32'(lit), 32'b00011);
        chk("start_ignored", 32'(state), 32'd1);
        start = 1'b0; tick = 1'b0; normal_t = 1'b0;
        level = 2'b00;
        btn = 5'b00011;
        cyc();
        btn = 5'b0;
        cyc();
        chk("clear_score", 32'(score), 32'd2);

        prn = 5'b11111; easy_t = 1'b1;
        for (int r = 0; r < 51; r++) begin
            if (r == 50) chk("score_252", 32'(score), 32'd252);
            tick = 1'b1;
            cyc();
            tick = 1'b0; btn = 5'b11111;
            cyc();
            btn = 5'b0;
            cyc();
        end
        chk("score_sat", 32'(score), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
